stopwatch_scan_mux: RTL and testbench
=====================================

# stopwatch_scan_mux

- Parametrised seven-segment scan multiplexer for the stopwatch.
- Time-multiplexes `NUM_DIGITS` BCD digits onto one hex-decoder input and an active-low anode vector.
- Keeps a circular buffer of the last `LAP_DEPTH` captured lap times, which can be recalled in turn.
- Optionally blanks leading zeros.
- Sits between the BCD time counters and the hex/seven-segment decoder.

## Interface

Parameters:
- `NUM_DIGITS`, default 4: number of displayed BCD digits, minimum 2.
- `DIV_WIDTH`, default 16: width of the refresh divider. The digit advances every 2^DIV_WIDTH clocks.
- `LAP_DEPTH`, default 4: number of stored laps. Power of two, minimum 2.
- `BLANK_LZ`, default 0: when 1, leading-zero digits are blanked.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `time_in` in 4*NUM_DIGITS: running time. Digit k is bits [4k+3:4k]; digit 0 is the rightmost.
- `run` in 1: stopwatch counting.
- `start_press` in 1: one-cycle pulse, already debounced.
- `lap_press` in 1: one-cycle pulse; captures a lap.
- `recall_press` in 1: one-cycle pulse; steps to the next older lap.
- `clear_press` in 1: one-cycle pulse; empties the lap buffer.
- `segmentNum` out 4: BCD value for the hex decoder.
- `an` out NUM_DIGITS: active-low anode enables. `an[k]` selects digit k.
- `lap_view` out 1: 1 = lap time shown, 0 = live time shown.
- `lap_sel` out clog2(LAP_DEPTH): age of the shown lap. 0 = newest.
- `lap_count` out clog2(LAP_DEPTH)+1: number of valid stored laps.

## Operation

- **Divider:** `DIV_WIDTH`-bit counter, +1 every clock, wraps naturally.
- **Tick:** a cycle in which the divider is all ones.
- **Digit select:** `digit_select` advances on each tick. It wraps from NUM_DIGITS-1 to 0.
- **Lap buffer:** `LAP_DEPTH` entries of 4*NUM_DIGITS bits, write pointer `wr_ptr`, and `lap_count`, which saturates at LAP_DEPTH.
  - On `lap_press`: `time_in` is written to slot `wr_ptr`, and `wr_ptr` increments modulo LAP_DEPTH.
  - When the buffer is full, the oldest entry is overwritten.
- **View state machine (LIVE, LAP):**
  - LIVE -> LAP on `lap_press`. `lap_sel` = 0.
  - LIVE -> LAP on `recall_press` when `lap_count` > 0. `lap_sel` = 0.
  - `recall_press` with `lap_count` = 0 is ignored.
  - LAP, `recall_press`: `lap_sel` +1. If `lap_sel` = lap_count-1, it wraps to 0. Only valid entries are visited.
  - LAP, `lap_press`: capture the lap, then `lap_sel` = 0 (the new lap is shown).
  - LAP -> LIVE on `start_press` while `run` = 1.
  - `start_press` with `run` = 0 does not change the view.
  - Any state, `clear_press`: `lap_count` = 0, `wr_ptr` = 0, `lap_sel` = 0, view = LIVE. Buffer contents may remain but are invalid.
- **Displayed slot** in LAP view: (wr_ptr - 1 - lap_sel) mod LAP_DEPTH.
- **Same-cycle priority:** rst > clear_press > lap_press > start_press&&run > recall_press. Lower-priority events in that cycle are dropped.
- **Leading-zero blanking:** when `BLANK_LZ` = 1, digit k > 0 is blanked if it and every digit above it are 0.
  - A blanked digit drives its `an` bit high (all anodes off) for its slot. `segmentNum` still carries 0.
  - Digit 0 is never blanked.
- **Registered outputs:** `an` and `segmentNum` are registered.
  - `an` = all ones except bit `digit_select` = 0, subject to blanking.
  - `segmentNum` = selected digit of the live or lap source.

## Timing

- **Reset values:** divider 0, `digit_select` 0, `an` all ones, `segmentNum` 0, `lap_view` 0, `lap_sel` 0, `lap_count` 0, `wr_ptr` 0.
- **First tick:** occurs on clock 2^DIV_WIDTH - 1 after reset release. `digit_select` = 1 from the following cycle.
- **Output latency:** `an`/`segmentNum` reflect `digit_select`, the view and `time_in` of the previous cycle. Latency is 1 clock.
- **Live digits:** `time_in` is not latched in LIVE view; a changing digit appears 1 clock later.
- **Press effects:**
  - A press at edge n updates the buffer and the view-state outputs (`lap_view`, `lap_sel`, `lap_count`) at edge n.
  - `an`/`segmentNum` change at edge n+1.
- **Reset mid-scan or mid-recall:** all state returns to reset values on the next edge.

## Test plan

Benches use DIV_WIDTH=2, NUM_DIGITS=4, LAP_DEPTH=4.

1. **Scan after reset.** Release reset with `time_in` = 16'h1234.
   - Immediately after release: `an` = 1111.
   - Then one clock after each tick, the outputs step: an=1110/seg=4, an=1101/seg=3, an=1011/seg=2, an=0111/seg=1.
   - After that the pattern wraps back to an=1110.
2. **Lap hold and release.** `time_in` = 16'h0512, `run` = 1, pulse `lap_press`, then change `time_in` to 16'h0999.
   - `lap_view` = 1; the display keeps showing 0512.
   - Pulse `start_press`: `lap_view` = 0, and the display shows 0999.
3. **Recall wrap.** Capture 5 laps: 0001, 0002, 0003, 0004, 0005.
   - `lap_count` = 4 (saturated), showing 0005.
   - Successive `recall_press`: 0004, 0003, 0002, then back to 0005. Lap 0001 is overwritten.
4. **Simultaneous events.**
   - `lap_press` and `clear_press` in the same cycle: `lap_count` = 0, view LIVE.
   - `lap_press` and `start_press` with `run` = 1: lap captured, view LAP.
5. **Recall with an empty buffer and stopped start.**
   - `recall_press` with `lap_count` = 0: no change.
   - `start_press` with `run` = 0 while in LAP view: view stays LAP.
6. **Leading-zero blanking.** `BLANK_LZ` = 1, `time_in` = 16'h0030.
   - Digits 3 and 2 give `an` = 1111 during their slots.
   - Digit 1 gives an=1101/seg=3; digit 0 gives an=1110/seg=0.
   - Mid-scan `rst`: `an` = 1111 on the next edge.

Source files
------------

// File: rtl/stopwatch_scan_mux.sv
// Seven-segment scan multiplexer for the stopwatch: scans live or recalled lap
// digits onto one BCD output and an active-low anode vector, with a circular lap store.
module stopwatch_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_WIDTH  = 16,
    parameter int LAP_DEPTH  = 4,
    parameter bit BLANK_LZ   = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4*NUM_DIGITS-1:0]      time_in,
    input  logic                         run,
    input  logic                         start_press,
    input  logic                         lap_press,
    input  logic                         recall_press,
    input  logic                         clear_press,
    output logic [3:0]                   segmentNum,
    output logic [NUM_DIGITS-1:0]        an,
    output logic                         lap_view,
    output logic [$clog2(LAP_DEPTH)-1:0] lap_sel,
    output logic [$clog2(LAP_DEPTH):0]   lap_count
);
    localparam int PW  = $clog2(LAP_DEPTH);
    localparam int CW  = PW + 1;
    localparam int DSW = $clog2(NUM_DIGITS);
    localparam int TW  = 4 * NUM_DIGITS;

    typedef enum logic {LIVE, LAP} view_e;

    logic [DIV_WIDTH-1:0]  div_q;
    logic [DSW-1:0]        dsel_q;
    view_e                 view_q;
    logic [PW-1:0]         wr_q;
    logic [PW-1:0]         sel_q;
    logic [CW-1:0]         cnt_q;
    logic [TW-1:0]         lap_mem [LAP_DEPTH];
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]            seg_q, seg_d;

    logic                  tick;
    logic                  capture;
    logic [PW-1:0]         rd_slot;
    logic [TW-1:0]         src;
    logic [NUM_DIGITS-1:0] lz;
    logic                  above;

    assign tick    = &div_q;
    assign capture = lap_press && !clear_press && !rst;
    // Newest lap sits just behind the write pointer; lap_sel walks further back in age.
    assign rd_slot = wr_q - PW'(1) - sel_q;
    assign src     = (view_q == LAP) ? lap_mem[rd_slot] : time_in;

    always_comb begin
        lz    = '0;
        above = 1'b1;
        seg_d = '0;
        an_d  = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz[k] = above && (src[4*k +: 4] == 4'd0);
            above = lz[k];
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dsel_q == DSW'(k)) begin
                seg_d   = src[4*k +: 4];
                an_d[k] = BLANK_LZ && (k > 0) && lz[k];
            end
        end
    end

    // Priority within a cycle: clear, lap, start-while-running, recall.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            dsel_q <= '0;
            view_q <= LIVE;
            wr_q   <= '0;
            sel_q  <= '0;
            cnt_q  <= '0;
            an_q   <= '1;
            seg_q  <= '0;
        end else begin
            div_q <= div_q + 1'b1;
            if (tick) begin
                dsel_q <= (dsel_q == DSW'(NUM_DIGITS - 1)) ? '0 : dsel_q + 1'b1;
            end
            an_q  <= an_d;
            seg_q <= seg_d;

            if (clear_press) begin
                cnt_q  <= '0;
                wr_q   <= '0;
                sel_q  <= '0;
                view_q <= LIVE;
            end else if (lap_press) begin
                wr_q   <= wr_q + 1'b1;
                sel_q  <= '0;
                view_q <= LAP;
                if (cnt_q != CW'(LAP_DEPTH)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (start_press && run) begin
                view_q <= LIVE;
            end else if (recall_press) begin
                case (view_q)
                    LIVE: begin
                        if (cnt_q != '0) begin
                            view_q <= LAP;
                            sel_q  <= '0;
                        end
                    end
                    LAP: begin
                        if ({1'b0, sel_q} == cnt_q - 1'b1) begin
                            sel_q <= '0;
                        end else begin
                            sel_q <= sel_q + 1'b1;
                        end
                    end
                    default: view_q <= LIVE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            lap_mem[wr_q] <= time_in;
        end
    end

    assign segmentNum = seg_q;
    assign an         = an_q;
    assign lap_view   = (view_q == LAP);
    assign lap_sel    = sel_q;
    assign lap_count  = cnt_q;
endmodule

// File: tb/tb_stopwatch_scan_mux.sv
// Scoreboard bench for stopwatch_scan_mux: one instance without and one with leading-zero blanking.
module tb_stopwatch_scan_mux;
    localparam int ND = 4;
    localparam int DW = 2;
    localparam int LD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] time_in = 16'h0;
    logic        run = 1'b0;
    logic        start_press = 1'b0;
    logic        lap_press = 1'b0;
    logic        recall_press = 1'b0;
    logic        clear_press = 1'b0;

    logic [3:0] seg0, seg1, an0, an1;
    logic       lv0, lv1;
    logic [1:0] ls0, ls1;
    logic [2:0] lc0, lc1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         dig;
        bit         blk;
        logic [3:0] an;
        logic [3:0] seg;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    stopwatch_scan_mux #(.NUM_DIGITS(ND), .DIV_WIDTH(DW), .LAP_DEPTH(LD), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .time_in(time_in), .run(run), .start_press(start_press),
        .lap_press(lap_press), .recall_press(recall_press), .clear_press(clear_press),
        .segmentNum(seg0), .an(an0), .lap_view(lv0), .lap_sel(ls0), .lap_count(lc0)
    );

    stopwatch_scan_mux #(.NUM_DIGITS(ND), .DIV_WIDTH(DW), .LAP_DEPTH(LD), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst(rst), .time_in(time_in), .run(run), .start_press(start_press),
        .lap_press(lap_press), .recall_press(recall_press), .clear_press(clear_press),
        .segmentNum(seg1), .an(an1), .lap_view(lv1), .lap_sel(ls1), .lap_count(lc1)
    );

    task automatic tick1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick1();
        tick1();
        cyc = 0;
        rst = 1'b0;
    endtask

    task automatic press(input bit lp, input bit sp, input bit rp, input bit cp);
        lap_press = lp;
        start_press = sp;
        recall_press = rp;
        clear_press = cp;
        tick1();
        lap_press = 1'b0;
        start_press = 1'b0;
        recall_press = 1'b0;
        clear_press = 1'b0;
    endtask

    function automatic exp_t mk(input logic [15:0] src, input int dig, input bit blk);
        exp_t e;
        e.dig = dig;
        e.blk = blk;
        e.seg = src[4*dig +: 4];
        if (blk && dig > 0 && (src >> (4 * dig)) == 16'h0) e.an = 4'hF;
        else e.an = ~(4'b0001 << dig);
        return e;
    endfunction

    task automatic push_frame(input logic [15:0] src, input bit blk);
        for (int d = 0; d < ND; d++) sb.push_back(mk(src, d, blk));
    endtask

    // Output after edge c shows the digit selected after edge c-1: ((c-1)/4) mod 4.
    task automatic drain();
        exp_t e;
        int n;
        int slot;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n = 0;
            slot = -1;
            do begin
                tick1();
                n++;
                slot = ((cyc - 1) / 4) % 4;
            end while (slot != e.dig && n < 20);
            checks++;
            if (slot != e.dig) begin
                failures++;
                $display("FAIL scan_timeout digit=%0d got_slot=%0d", e.dig, slot);
            end else if ({(e.blk ? an1 : an0), (e.blk ? seg1 : seg0)} !== {e.an, e.seg}) begin
                failures++;
                $display("FAIL scan_digit%0d blk=%0d got an=%b seg=%h exp an=%b seg=%h",
                         e.dig, e.blk, e.blk ? an1 : an0, e.blk ? seg1 : seg0, e.an, e.seg);
            end
        end
    endtask

    task automatic test_reset();
        time_in = 16'h1234;
        do_reset();
        checks++;
        if ({an0, seg0, an1, seg1} !== {4'hF, 4'h0, 4'hF, 4'h0}) begin
            failures++;
            $display("FAIL reset_display got an0=%b seg0=%h an1=%b seg1=%h exp an=1111 seg=0", an0, seg0, an1, seg1);
        end
        checks++;
        if ({lv0, ls0, lc0, lv1, ls1, lc1} !== 12'h000) begin
            failures++;
            $display("FAIL reset_state got %b %b %b / %b %b %b exp zeros", lv0, ls0, lc0, lv1, ls1, lc1);
        end
    endtask

    task automatic test_scan();
        push_frame(16'h1234, 1'b0);
        sb.push_back(mk(16'h1234, 0, 1'b0));
        drain();
    endtask

    task automatic test_lap_hold();
        time_in = 16'h0512;
        run = 1'b1;
        press(1, 0, 0, 0);
        checks++;
        if ({lv0, ls0, lc0} !== {1'b1, 2'd0, 3'd1}) begin
            failures++;
            $display("FAIL lap_hold_state got %b_%b_%b exp 1_00_001", lv0, ls0, lc0);
        end
        time_in = 16'h0999;
        push_frame(16'h0512, 1'b0);
        drain();
        press(0, 1, 0, 0);
        checks++;
        if (lv0 !== 1'b0) begin
            failures++;
            $display("FAIL lap_release_view got %b exp 0", lv0);
        end
        push_frame(16'h0999, 1'b0);
        drain();
    endtask

    task automatic test_recall_wrap();
        logic [15:0] exp_lap [4];
        exp_lap[0] = 16'h0005;
        exp_lap[1] = 16'h0004;
        exp_lap[2] = 16'h0003;
        exp_lap[3] = 16'h0002;
        press(0, 0, 0, 1);
        for (int i = 1; i <= 5; i++) begin
            time_in = 16'(i);
            press(1, 0, 0, 0);
        end
        time_in = 16'h0999;
        checks++;
        if ({lv0, ls0, lc0} !== {1'b1, 2'd0, 3'd4}) begin
            failures++;
            $display("FAIL recall_full_state got %b_%b_%b exp 1_00_100", lv0, ls0, lc0);
        end
        sb.push_back(mk(exp_lap[0], 0, 1'b0));
        drain();
        for (int r = 1; r <= 4; r++) begin
            press(0, 0, 1, 0);
            checks++;
            if (ls0 !== 2'(r % 4)) begin
                failures++;
                $display("FAIL recall_sel%0d got %0d exp %0d", r, ls0, r % 4);
            end
            sb.push_back(mk(exp_lap[r % 4], 0, 1'b0));
            drain();
        end
    endtask

    task automatic test_simultaneous();
        press(1, 0, 0, 1);
        checks++;
        if ({lv0, ls0, lc0} !== 6'b0) begin
            failures++;
            $display("FAIL lap_and_clear got %b_%b_%b exp 0_00_000", lv0, ls0, lc0);
        end
        time_in = 16'h0777;
        run = 1'b1;
        press(1, 1, 0, 0);
        checks++;
        if ({lv0, ls0, lc0} !== {1'b1, 2'd0, 3'd1}) begin
            failures++;
            $display("FAIL lap_and_start got %b_%b_%b exp 1_00_001", lv0, ls0, lc0);
        end
        time_in = 16'h0888;
        sb.push_back(mk(16'h0777, 0, 1'b0));
        drain();
    endtask

    task automatic test_empty_stopped();
        press(0, 0, 0, 1);
        press(0, 0, 1, 0);
        checks++;
        if ({lv0, ls0, lc0} !== 6'b0) begin
            failures++;
            $display("FAIL recall_empty got %b_%b_%b exp 0_00_000", lv0, ls0, lc0);
        end
        time_in = 16'h0042;
        press(1, 0, 0, 0);
        run = 1'b0;
        press(0, 1, 0, 0);
        checks++;
        if ({lv0, ls0, lc0} !== {1'b1, 2'd0, 3'd1}) begin
            failures++;
            $display("FAIL start_stopped got %b_%b_%b exp 1_00_001", lv0, ls0, lc0);
        end
        press(0, 0, 1, 0);
        checks++;
        if (ls0 !== 2'd0) begin
            failures++;
            $display("FAIL recall_single_wrap got %0d exp 0", ls0);
        end
        time_in = 16'h0000;
        sb.push_back(mk(16'h0042, 0, 1'b0));
        sb.push_back(mk(16'h0042, 1, 1'b0));
        drain();
    endtask

    task automatic test_blanking();
        run = 1'b1;
        press(0, 0, 0, 1);
        time_in = 16'h0030;
        push_frame(16'h0030, 1'b1);
        push_frame(16'h0030, 1'b0);
        drain();
        press(1, 0, 0, 0);
        tick1();
        tick1();
        rst = 1'b1;
        tick1();
        rst = 1'b0;
        checks++;
        if ({an0, an1, seg0, seg1} !== {4'hF, 4'hF, 4'h0, 4'h0}) begin
            failures++;
            $display("FAIL midscan_reset_display got an0=%b an1=%b seg0=%h seg1=%h exp 1111/1111/0/0", an0, an1, seg0, seg1);
        end
        checks++;
        if ({lv1, ls1, lc1} !== 6'b0) begin
            failures++;
            $display("FAIL midscan_reset_state got %b_%b_%b exp 0_00_000", lv1, ls1, lc1);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lap_hold();
        test_recall_wrap();
        test_simultaneous();
        test_empty_stopped();
        test_blanking();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
